// File: rtl/bp_request_sequencer.sv
// Initiator-side sequencer for the gshare predictor: issues predicts, queues them in order, replays resolves.
// Optional BP_STATS_EN builds saturating resolve/mispredict counters; otherwise the stat ports read 0.
module bp_request_sequencer #(
  parameter int W        = 32,
  parameter int DEPTH    = 4,
  parameter int PRED_LAT = 2,
  parameter int RES_LAT  = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       fetch_valid,
  input  logic [W-1:0]               fetch_pc,
  output logic                       fetch_ready,
  output logic                       pred_valid,
  output logic                       pred_taken,
  output logic [W-1:0]               pred_target,
  input  logic                       ex_valid,
  input  logic [W-1:0]               ex_pc,
  input  logic [W-1:0]               ex_target,
  output logic                       ex_ready,
  output logic                       mispredict,
  output logic [W-1:0]               redirect_pc,
  output logic                       seq_err,
  output logic [$clog2(DEPTH):0]     q_count,
  output logic [W-1:0]               bp_pc,
  output logic                       bp_start_pred,
  output logic                       bp_start_resolve,
  output logic [W-1:0]               bp_actual_target,
  output logic                       bp_pr_hit,
  input  logic                       bp_br_pred,
  input  logic [W-1:0]               bp_target,
  output logic [31:0]                stat_total,
  output logic [31:0]                stat_mispred
);

  localparam int AW      = $clog2(DEPTH);
  localparam int CW      = AW + 1;
  localparam int LAT_MAX = (PRED_LAT > RES_LAT) ? PRED_LAT : RES_LAT;
  localparam int LW      = $clog2(LAT_MAX + 1);

  typedef enum logic [2:0] {IDLE, PRED, PWAIT, RES, RWAIT} state_t;

  typedef struct packed {
    logic [W-1:0] pc;
    logic         taken;
    logic [W-1:0] target;
  } entry_t;

  state_t        state;
  entry_t        q [DEPTH];
  entry_t        hd;
  logic [AW-1:0] head, tail;
  logic [W-1:0]  req_pc, ex_tgt;
  logic [LW-1:0] lat;
  logic          res_go, fetch_go, push, res_done, mis_hit;

  assign hd = q[head];

  // Resolve wins arbitration; a pending resolve blocks fetch even when the queue has room.
  assign res_go   = !rst && (state == IDLE) && ex_valid && (q_count != '0);
  assign fetch_go = !rst && (state == IDLE) && !(ex_valid && (q_count != '0)) &&
                    fetch_valid && (q_count != CW'(DEPTH));
  assign ex_ready    = res_go;
  assign fetch_ready = fetch_go;

  assign push     = (state == PWAIT) && (lat == '0);
  assign res_done = (state == RWAIT) && (lat == '0);
  assign mis_hit  = (ex_tgt != hd.target);

  always_ff @(posedge clk) begin
    if (!rst && push) q[tail] <= '{pc: req_pc, taken: bp_br_pred, target: bp_target};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      head             <= '0;
      tail             <= '0;
      q_count          <= '0;
      req_pc           <= '0;
      ex_tgt           <= '0;
      lat              <= '0;
      pred_valid       <= 1'b0;
      pred_taken       <= 1'b0;
      pred_target      <= '0;
      mispredict       <= 1'b0;
      redirect_pc      <= '0;
      seq_err          <= 1'b0;
      bp_pc            <= '0;
      bp_start_pred    <= 1'b0;
      bp_start_resolve <= 1'b0;
      bp_actual_target <= '0;
      bp_pr_hit        <= 1'b0;
    end else begin
      pred_valid       <= 1'b0;
      mispredict       <= 1'b0;
      bp_start_pred    <= 1'b0;
      bp_start_resolve <= 1'b0;
      case (state)
        IDLE: begin
          if (res_go) begin
            req_pc           <= ex_pc;
            ex_tgt           <= ex_target;
            bp_pc            <= hd.pc;
            bp_actual_target <= ex_target;
            bp_pr_hit        <= hd.taken;
            bp_start_resolve <= 1'b1;
            state            <= RES;
          end else if (fetch_go) begin
            req_pc        <= fetch_pc;
            bp_pc         <= fetch_pc;
            bp_start_pred <= 1'b1;
            state         <= PRED;
          end
        end
        PRED: begin
          lat   <= LW'(PRED_LAT - 1);
          state <= PWAIT;
        end
        PWAIT: begin
          if (lat == '0) begin
            tail        <= tail + 1'b1;
            q_count     <= q_count + 1'b1;
            pred_valid  <= 1'b1;
            pred_taken  <= bp_br_pred;
            pred_target <= bp_target;
            bp_pc       <= '0;
            state       <= IDLE;
          end else begin
            lat <= lat - 1'b1;
          end
        end
        RES: begin
          if (req_pc != hd.pc) seq_err <= 1'b1;
          lat   <= LW'(RES_LAT - 1);
          state <= RWAIT;
        end
        RWAIT: begin
          if (lat == '0) begin
            // A wrong target invalidates every younger prediction, so the whole queue goes.
            if (mis_hit) begin
              mispredict  <= 1'b1;
              redirect_pc <= ex_tgt;
              head        <= '0;
              tail        <= '0;
              q_count     <= '0;
            end else begin
              head    <= head + 1'b1;
              q_count <= q_count - 1'b1;
            end
            bp_pc            <= '0;
            bp_actual_target <= '0;
            bp_pr_hit        <= 1'b0;
            state            <= IDLE;
          end else begin
            lat <= lat - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef BP_STATS_EN
  logic [31:0] tot_cnt, mis_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      tot_cnt <= '0;
      mis_cnt <= '0;
    end else if (res_done) begin
      if (tot_cnt != '1) tot_cnt <= tot_cnt + 1'b1;
      if (mis_hit && (mis_cnt != '1)) mis_cnt <= mis_cnt + 1'b1;
    end
  end

  assign stat_total   = tot_cnt;
  assign stat_mispred = mis_cnt;
`else
  assign stat_total   = '0;
  assign stat_mispred = '0;
`endif

endmodule
